// File: rtl/kvt_scfifo_rd_ctrl.sv
// kvt_scfifo_rd_ctrl
// Drain controller for the kvt_scfifo read port (non-showahead, registered q).
// Issues fifo_rdreq on a credit basis, captures fifo_q one cycle later into a
// 3-entry elastic buffer and presents the words as a valid/ready stream.
// fifo_rdreq never depends on m_ready.
//
// Optional feature: define KVT_SCFIFO_RD_CTRL_STATS_EN to add the word_cnt /
// stall_cnt statistics ports and counters.

module kvt_scfifo_rd_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef KVT_SCFIFO_RD_CTRL_STATS_EN
  ,
  output logic [31:0]       word_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  // Buffer occupancy doubles as the controller state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_FULL  = 2'd3
  } occ_t;

  occ_t              count;
  occ_t              count_nxt;
  logic [DATA_W-1:0] buf_mem [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic              inflight;
  logic              wr_en;
  logic              pop;
  logic [2:0]        credits_used;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check: every buffered word and every in-flight read holds a slot.
  always_comb begin
    credits_used = {1'b0, count} + {2'b0, inflight};
    fifo_rdreq   = !reset && !fifo_empty && (credits_used < 3'd3);
  end

  // Write/pop strobes for the elastic buffer.
  always_comb begin
    wr_en = inflight;
    pop   = m_valid && m_ready;
  end

  // Output word is the head slot.
  always_comb begin
    m_data = '0;
    case (rd_ptr)
      2'd0:    m_data = buf_mem[0];
      2'd1:    m_data = buf_mem[1];
      2'd2:    m_data = buf_mem[2];
      default: m_data = '0;
    endcase
  end

  // Occupancy transitions; a write into FULL without a pop is excluded by the credit rule.
  always_comb begin
    count_nxt = count;
    case (count)
      OCC_EMPTY: if (wr_en)          count_nxt = OCC_ONE;
      OCC_ONE: begin
        if (wr_en && !pop)           count_nxt = OCC_TWO;
        else if (!wr_en && pop)      count_nxt = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (wr_en && !pop)           count_nxt = OCC_FULL;
        else if (!wr_en && pop)      count_nxt = OCC_ONE;
      end
      OCC_FULL:  if (!wr_en && pop)  count_nxt = OCC_TWO;
      default:                       count_nxt = OCC_EMPTY;
    endcase
  end

  // Occupancy state with registered m_valid derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= OCC_EMPTY;
      m_valid <= 1'b0;
    end else begin
      count   <= count_nxt;
      m_valid <= (count_nxt != OCC_EMPTY);
    end
  end

  // Read-request tracking and pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= fifo_rdreq;
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // Capture the FIFO word returned for last cycle's request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) buf_mem[i] <= '0;
    end else if (wr_en) begin
      buf_mem[wr_ptr] <= fifo_q;
    end
  end

`ifdef KVT_SCFIFO_RD_CTRL_STATS_EN
  // Delivered-word and backpressure-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                 word_cnt  <= word_cnt + 32'd1;
      if (m_valid && !m_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kvt_scfifo_rd_ctrl.sv
// Testbench for kvt_scfifo_rd_ctrl with a behavioural non-showahead FIFO.
// Defining KVT_SCFIFO_RD_CTRL_STATS_EN also exercises the statistics counters.

module tb_kvt_scfifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty_r = 1'b1;
  logic       hold = 1'b0;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic [7:0] fifo_q = '0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = '0;
`ifdef KVT_SCFIFO_RD_CTRL_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  assign fifo_empty = fifo_empty_r | hold;

  always #5 clk = ~clk;

  kvt_scfifo_rd_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .fifo_q     (fifo_q),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef KVT_SCFIFO_RD_CTRL_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Behavioural FIFO: registered q, empty flag updated after each edge.
  logic [7:0] fq[$];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      fifo_q       <= '0;
      fifo_empty_r <= 1'b1;
    end else begin
      if (fifo_rdreq && fq.size() != 0) fifo_q <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
      fifo_empty_r <= (fq.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Load n words while the DUT sees an empty FIFO; returns at a negedge.
  task automatic preload(input int n, input logic [7:0] base);
    hold = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = base + 8'(i);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  typedef struct {
    bit         load;
    logic       rdy;
    logic       rdreq;
    logic       valid;
    bit         cd;
    logic [7:0] data;
  } vec_t;

  vec_t vt[26];

  initial begin
    logic [7:0] expq[$];
    logic [7:0] rx[$];
    int sent, got, cyc, bad_rd;
    logic prev_stall;
    logic [7:0] prev_data;

    // Streaming with m_ready=1: reads in cycles 0..7, words 01..08 from cycle 2.
    vt[0]  = '{1, 1, 1, 0, 0, 8'h00};
    vt[1]  = '{0, 1, 1, 0, 0, 8'h00};
    vt[2]  = '{0, 1, 1, 1, 1, 8'h01};
    vt[3]  = '{0, 1, 1, 1, 1, 8'h02};
    vt[4]  = '{0, 1, 1, 1, 1, 8'h03};
    vt[5]  = '{0, 1, 1, 1, 1, 8'h04};
    vt[6]  = '{0, 1, 1, 1, 1, 8'h05};
    vt[7]  = '{0, 1, 1, 1, 1, 8'h06};
    vt[8]  = '{0, 1, 0, 1, 1, 8'h07};
    vt[9]  = '{0, 1, 0, 1, 1, 8'h08};
    vt[10] = '{0, 1, 0, 0, 0, 8'h00};
    // Backpressure: 3 reads then stall with 01 held; release at cycle 6.
    vt[11] = '{1, 0, 1, 0, 0, 8'h00};
    vt[12] = '{0, 0, 1, 0, 0, 8'h00};
    vt[13] = '{0, 0, 1, 1, 1, 8'h01};
    vt[14] = '{0, 0, 0, 1, 1, 8'h01};
    vt[15] = '{0, 0, 0, 1, 1, 8'h01};
    vt[16] = '{0, 0, 0, 1, 1, 8'h01};
    vt[17] = '{0, 1, 0, 1, 1, 8'h01};
    vt[18] = '{0, 1, 1, 1, 1, 8'h02};
    vt[19] = '{0, 1, 1, 1, 1, 8'h03};
    vt[20] = '{0, 1, 1, 1, 1, 8'h04};
    vt[21] = '{0, 1, 1, 1, 1, 8'h05};
    vt[22] = '{0, 1, 1, 1, 1, 8'h06};
    vt[23] = '{0, 1, 0, 1, 1, 8'h07};
    vt[24] = '{0, 1, 0, 1, 1, 8'h08};
    vt[25] = '{0, 1, 0, 0, 0, 8'h00};

    // Reset and idle.
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("idle_rdreq", {31'd0, fifo_rdreq}, 32'd0);
      chk("idle_valid", {31'd0, m_valid}, 32'd0);
      chk("idle_data", {24'd0, m_data}, 32'd0);
    end

    // Table-driven streaming and backpressure sequences.
    for (int i = 0; i < 26; i++) begin
      if (vt[i].load) preload(8, 8'h01);
      @(negedge clk);
      hold    = 1'b0;
      m_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_rdreq", i), {31'd0, fifo_rdreq}, {31'd0, vt[i].rdreq});
      chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vt[i].valid});
      if (vt[i].cd) chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, vt[i].data});
    end

    // Reset mid-stream with count=2 and one read in flight.
    m_ready = 1'b0;
    preload(8, 8'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hold = 1'b0;
    end
    @(negedge clk); #1;
    chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
    chk("pre_rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, m_data}, 32'd0);
    chk("mid_rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      push_en   = (i < 3);
      push_data = 8'hA0 + 8'(i);
      m_ready   = 1'b1;
      #1;
      if (m_valid && m_ready) rx.push_back(m_data);
    end
    push_en = 1'b0;
    chk("post_rst_words", rx.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rx.size()) chk("post_rst_data", {24'd0, rx[i]}, {24'd0, 8'hA0 + 8'(i)});

    // Random backpressure with random refill, scoreboarded.
    sent = 0; got = 0; cyc = 0; bad_rd = 0;
    prev_stall = 1'b0; prev_data = '0;
    while (got < 10000 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      push_en = (sent < 10000) && ($urandom_range(0, 3) != 0);
      if (push_en) begin
        push_data = 8'($urandom);
        expq.push_back(push_data);
        sent++;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (fifo_rdreq && fifo_empty) bad_rd++;
      if (prev_stall) chk("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, prev_data});
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("rand_extra_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        else chk("rand_data", {24'd0, m_data}, {24'd0, expq.pop_front()});
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    push_en = 1'b0;
    chk("rand_done", got, 32'd10000);
    chk("rdreq_while_empty", bad_rd, 32'd0);

`ifdef KVT_SCFIFO_RD_CTRL_STATS_EN
    // 5 words delivered with exactly 7 stall cycles.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b0;
    preload(5, 8'h50);
    got = 0; cyc = 0; bad_rd = 0;
    while (got < 5 && cyc < 200) begin
      @(negedge clk);
      hold    = 1'b0;
      cyc++;
      m_ready = (bad_rd >= 7);
      #1;
      if (m_valid && !m_ready) bad_rd++;
      if (m_valid && m_ready) got++;
    end
    @(negedge clk); #1;
    chk("word_cnt", word_cnt, 32'd5);
    chk("stall_cnt", stall_cnt, 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kvt_scfifo_rd_ctrl.md
# kvt_scfifo_rd_ctrl

Read-side drain controller sitting directly downstream of the single-clock FIFO (kvt_scfifo). Issues `fifo_rdreq` against the FIFO's non-showahead, registered-output read port and captures `fifo_q` one cycle later. Re-presents the words as a valid/ready stream through a 3-entry elastic buffer. Sustains one word per clock with no combinational path from `m_ready` to `fifo_rdreq`.

## Interface
Parameters:
- `DATA_W`, 8 — word width; must match the FIFO data width.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `fifo_empty`  in  1  — FIFO empty flag.
- `fifo_rdreq`  out  1  — FIFO read request; one word popped per high cycle.
- `fifo_q`  in  DATA_W  — FIFO read data, valid the cycle after `fifo_rdreq`.
- `m_valid`  out  1  — output word valid.
- `m_data`  out  DATA_W  — output word.
- `m_ready`  in  1  — downstream accept.
- `word_cnt`  out  32  — words delivered; present only with the stats macro.
- `stall_cnt`  out  32  — backpressure cycles; present only with the stats macro.

## Operation
- State registers:
  - `buf[0..2]` — data storage.
  - `wr_ptr`, `rd_ptr` — range 0..2, wrap 2→0.
  - `count` — range 0..3.
  - `inflight` — 1 bit; registered copy of `fifo_rdreq`.
- Request: `fifo_rdreq = !reset && !fifo_empty && (count + inflight) < 3`. Depends on registered state and `fifo_empty` only; never on `m_ready`.
- Capture: when `inflight`=1, `fifo_q` is written to `buf[wr_ptr]` and `wr_ptr` advances.
- Output:
  - `m_valid = (count != 0)`.
  - `m_data = buf[rd_ptr]`.
  - Pop = `m_valid && m_ready`; a pop advances `rd_ptr`.
- Count update:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop, or on neither.
- Occupancy states (equal to `count`):
  - EMPTY(0) → ONE on write.
  - ONE ↔ TWO ↔ FULL(3) on net +1 / −1.
  - FULL with write and no pop cannot occur: the credit rule reserves a slot for every in-flight read.
- Ordering: words leave in FIFO order. While `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` stay stable.
- Credit rule guarantees `fifo_rdreq` is never high while `fifo_empty`=1 and the buffer never overflows.
- Reset:
  - Asynchronously clears `count`, pointers, `inflight` and all `buf` entries to 0.
  - Outputs during and after reset: `m_valid`=0, `m_data`=0, `fifo_rdreq`=0.
  - A word in flight at reset assertion is discarded. The FIFO shares `reset`, so no word is lost relative to FIFO state.

## Timing
- Latency:
  - `fifo_empty` falls in cycle N with buffer idle → `fifo_rdreq`=1 in cycle N.
  - Data captured at end of N+1.
  - `m_valid`=1 in cycle N+2.
- Throughput:
  - Credit loop is rdreq(N) → write(N+1) → pop(N+2) → count freed(N+3), i.e. 3 cycles, so 3 entries sustain one word per cycle with `m_ready`=1.
  - Steady state: `count`=1, `inflight`=1.
- Backpressure:
  - `m_ready` low for K cycles → `fifo_rdreq` drops once `count + inflight` = 3 (at most 2 further reads after the stall starts).
  - Resumes the cycle after the first pop frees a credit.
- FIFO emptying mid-stream: `fifo_rdreq` drops the same cycle; buffered words continue to drain normally.

## Configuration
- `KVT_SCFIFO_RD_CTRL_STATS_EN` defined:
  - Adds ports `word_cnt` and `stall_cnt`.
  - `word_cnt` +1 per pop.
  - `stall_cnt` +1 per cycle with `m_valid && !m_ready`.
  - Both wrap modulo 2^32 and reset asynchronously to 0.
- Undefined: both ports and their counters are absent; behaviour is otherwise identical.

## Test plan
- Reset then idle (`fifo_empty`=1): `fifo_rdreq`=0, `m_valid`=0, `m_data`=0 for 20 cycles.
- Preload 8 words 0x01..0x08, `m_ready`=1:
  - First `fifo_rdreq` at cycle N.
  - `m_valid` from N+2; words 0x01..0x08 on 8 consecutive cycles.
  - `fifo_rdreq` low after the 8th read.
- Preload 8 words, hold `m_ready`=0:
  - Exactly 3 rdreq pulses, then `count`=3.
  - `m_data`=0x01 stable.
  - Release → remaining words in order, no gaps after the first 3.
- Random `m_ready` (50%) with random FIFO refill, 10k words:
  - Output matches the input scoreboard.
  - Never `fifo_rdreq` && `fifo_empty`.
  - `count` never exceeds 3.
- Assert `reset` mid-stream with `inflight`=1 and `count`=2: outputs clear the same cycle; after release, the first word equals the first word written after reset.
- With `KVT_SCFIFO_RD_CTRL_STATS_EN`:
  - 5 words delivered with 7 stall cycles → `word_cnt`=5, `stall_cnt`=7.
  - Preset to 0xFFFFFFFF wraps to 0 on the next increment.
